// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared crossbar types plus slave memory endpoint FSM states and constants
package cross_bar_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, ACK, RELEASE} slave_mem_state_t;
    localparam data_t MISALIGNED_RDATA = 32'hBAD0_ADD0;
endpackage

// File: rtl/cross_bar_slave_ram.sv
// cross_bar_slave_ram: single-port synchronous RAM, 1-cycle read, write-first, no array reset
module cross_bar_slave_ram
    import cross_bar_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  data_t                    wdata,
    output data_t                    rdata
);
    data_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/cross_bar_slave_mem.sv
// cross_bar_slave_mem: memory-backed crossbar slave with programmable wait states and
// saturating transaction statistics
module cross_bar_slave_mem
    import cross_bar_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             slave_req,
    input  addr_t            slave_addr,
    input  logic             slave_cmd,
    input  data_t            slave_wdata,
    output logic             slave_ack,
    output data_t            slave_rdata,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int AW = $clog2(DEPTH);

    slave_mem_state_t state;
    logic [3:0]       wcnt;
    logic [AW+1:0]    addr_q;
    logic             cmd_q;
    data_t            wdata_q;
    data_t            ram_q;
    logic             misaligned;
    logic             ram_we;
    logic             unused_addr;

    // upper address bits (slave select etc.) alias away
    assign unused_addr = ^slave_addr[ADDR_W-1:AW+2];
    assign misaligned  = |addr_q[1:0];
    // gated by aresetn so a reset landing on ACCESS still drops the write
    assign ram_we      = aresetn && state == ACCESS && cmd_q && !misaligned;

    cross_bar_slave_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state       <= IDLE;
            wcnt        <= '0;
            slave_ack   <= 1'b0;
            slave_rdata <= '0;
            wr_count    <= '0;
            rd_count    <= '0;
            err_count   <= '0;
        end else begin
            slave_ack <= state == ACK;
            case (state)
                IDLE: if (slave_req) begin
                    addr_q  <= slave_addr[AW+1:0];
                    cmd_q   <= slave_cmd;
                    wdata_q <= slave_wdata;
                    wcnt    <= 4'(WAIT_CYCLES);
                    state   <= WAIT_CYCLES > 0 ? WAIT : ACCESS;
                end
                WAIT: begin
                    wcnt  <= wcnt - 4'd1;
                    state <= wcnt == 4'd1 ? ACCESS : WAIT;
                end
                ACCESS: state <= ACK;
                ACK: begin
                    state <= RELEASE;
                    if (misaligned) begin
                        err_count <= err_count + CNT_W'(!(&err_count));
                        if (!cmd_q) slave_rdata <= MISALIGNED_RDATA;
                    end else if (cmd_q) begin
                        wr_count <= wr_count + CNT_W'(!(&wr_count));
                    end else begin
                        rd_count    <= rd_count + CNT_W'(!(&rd_count));
                        slave_rdata <= ram_q;
                    end
                end
                RELEASE: if (!slave_req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cross_bar_slave_mem.md
Name: cross_bar_slave_mem

Overview:
- Synthesizable memory-backed slave endpoint for the cross_bar_top slave-side req/ack interface.
- It is the responder for master requests routed through the crossbar.
- Accepts single read/write transactions, inserts a programmable number of wait cycles, returns a single-cycle ack with read data, and keeps transaction statistics.
- Used as an on-chip scratch RAM behind any crossbar slave port, and as the synthesizable replacement for the behavioural slave model in system benches.

Parameters:
DEPTH, 256, number of DATA_W-bit words; power of two, min 4
WAIT_CYCLES, 2, extra cycles between request accept and ack; 0..15
CNT_W, 16, width of the statistics counters

Ports:
clk  input  1  block clock
aresetn  input  1  reset, synchronous, active-low
slave_req  input  1  request valid; held by requester until ack seen
slave_addr  input  ADDR_W (addr_t)  byte address
slave_cmd  input  1  1 = write, 0 = read
slave_wdata  input  DATA_W (data_t)  write data
slave_ack  output  1  single-cycle completion strobe
slave_rdata  output  DATA_W (data_t)  read data, valid in ack cycle
wr_count  output  CNT_W  completed writes, saturating
rd_count  output  CNT_W  completed reads, saturating
err_count  output  CNT_W  misaligned accesses, saturating

Behaviour:
- Interface contract: clk and aresetn only; reset is synchronous and active-low (sampled on rising clk edge only).
- Reset: state IDLE; slave_ack=0; slave_rdata=0; all counters 0; wait counter 0. Memory contents are not cleared.
- Reset asserted mid-transaction aborts it. A write not yet performed is dropped, and no ack is issued.
- Address decode: word index = slave_addr[$clog2(DEPTH)+1:2]. Upper bits, including slave-select bits, are ignored, so addresses alias modulo DEPTH*4.
- Misaligned access (slave_addr[1:0] != 0):
  - still acknowledged with normal latency;
  - write suppressed;
  - rdata = 32'hBAD0_ADD0 for reads;
  - err_count increments; wr_count and rd_count do not.
- FSM states: IDLE, WAIT, ACCESS, ACK, RELEASE.
- IDLE: slave_req sampled 1 at edge k. Capture addr, cmd, wdata. Load wait counter = WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT: decrement the counter each cycle; go to ACCESS when it reaches 1.
- ACCESS: one cycle. Write to RAM, or issue the synchronous RAM read. Go to ACK.
- ACK:
  - slave_ack=1 for exactly one cycle, visible after edge k+WAIT_CYCLES+2;
  - slave_rdata loaded with read data (reads) or left unchanged (writes);
  - counter update in the same edge;
  - go to RELEASE.
- RELEASE: stay until slave_req sampled 0, then IDLE. This blocks re-acceptance of a held request. Back-to-back transactions need at least one req-low cycle.
- slave_rdata holds its last value until the next read ack or reset.
- Input changes after capture are ignored until the next IDLE accept.
- Counters saturate at all-ones and do not wrap.
- Total latency, accept edge to ack high: WAIT_CYCLES+2 cycles.

Decomposition:
- cross_bar_pkg additions:
  - slave_mem_state_t enum (IDLE, WAIT, ACCESS, ACK, RELEASE);
  - localparam MISALIGNED_RDATA = 32'hBAD0_ADD0.
- Reuse existing ADDR_W, DATA_W, addr_t, data_t from cross_bar_pkg.
- One sub-module: cross_bar_slave_ram.
  - Single-port synchronous RAM, DEPTH x DATA_W, 1-cycle read, write-first.
  - No reset on the array.

Test Plan:
- Reset, then write 0xDEADC0DE to 0xA0000000 with WAIT_CYCLES=2 -> ack high exactly 4 cycles after accept for 1 cycle; wr_count=1.
- Read 0xA0000000 after the previous write -> rdata=0xDEADC0DE in ack cycle and held afterwards; rd_count=1.
- Write 0x0F0F0F0F to 0xD2000004, then read 0x00000404 (DEPTH=256, aliases word 1) -> rdata=0x0F0F0F0F.
- Write to 0x00000002, then read 0x00000002 -> both acked; read rdata=0xBAD0ADD0; err_count=2; word 0 unchanged.
- Hold slave_req high for 10 cycles after ack -> no second ack; one cycle after req drops and re-rises, a new transaction is accepted.
- Assert aresetn=0 during WAIT of a write to 0x10 -> no ack; counters 0. After reset, read 0x10 returns the pre-write contents; wr_count stays 0.
